// File: rtl/sinewave_gen_axil_slave_if.sv
// AXI4-Lite bus bundle for the sinewave generator register file.
// master drives AW/W/AR valids, addr, data, B/R ready; slave answers.
interface sinewave_gen_axil_slave_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [2:0]      S_AXI_AWPROT;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic [2:0]      S_AXI_ARPROT;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/sinewave_gen_axil_slave.sv
// AXI4-Lite register file (4 x 32b) for the sinewave generator core.
// Ports: ACLK, ARESETN, s_axi (slave bus), reg0..reg3, cfg_update(+idx).
module sinewave_gen_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic ACLK,
    input  logic ARESETN,
    sinewave_gen_axil_slave_if.slave s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_ctrl,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_phase_inc,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_amplitude,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_offset,
    output logic cfg_update,
    output logic [1:0] cfg_update_idx
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    logic          rst_done;
    logic          aw_held;
    logic          w_held;
    logic          bvalid;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic [DW-1:0] regs [4];

    logic          awready;
    logic          wready;
    logic          arready;
    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          commit;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [1:0]    wr_idx;
    logic [1:0]    rd_idx;
    logic [DW-1:0] merged;

    // Readiness waits one cycle after reset release (rst_done).
    assign awready = !aw_held && !bvalid && rst_done;
    assign wready  = !w_held && !bvalid && rst_done;
    assign arready = !rvalid && rst_done;

    assign aw_hs = s_axi.S_AXI_AWVALID && awready;
    assign w_hs  = s_axi.S_AXI_WVALID && wready;
    assign ar_hs = s_axi.S_AXI_ARVALID && arready;

    // Commit as soon as both halves exist, held or arriving now.
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_addr = aw_held ? aw_addr_q : s_axi.S_AXI_AWADDR;
    assign wr_data = w_held ? w_data_q : s_axi.S_AXI_WDATA;
    assign wr_strb = w_held ? w_strb_q : s_axi.S_AXI_WSTRB;
    assign wr_idx  = wr_addr[3:2];
    assign rd_idx  = s_axi.S_AXI_ARADDR[3:2];

    always_comb begin
        merged = regs[wr_idx];
        for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) begin
                merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_done       <= 1'b0;
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            bvalid         <= 1'b0;
            rvalid         <= 1'b0;
            rdata          <= '0;
            aw_addr_q      <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            cfg_update     <= 1'b0;
            cfg_update_idx <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            rst_done   <= 1'b1;
            cfg_update <= commit;
            if (commit) begin
                aw_held        <= 1'b0;
                w_held         <= 1'b0;
                regs[wr_idx]   <= merged;
                bvalid         <= 1'b1;
                cfg_update_idx <= wr_idx;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s_axi.S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi.S_AXI_WDATA;
                    w_strb_q <= s_axi.S_AXI_WSTRB;
                end
                if (bvalid && s_axi.S_AXI_BREADY) begin
                    bvalid <= 1'b0;
                end
            end
            // Same-edge read sees the pre-commit register value.
            if (ar_hs) begin
                rdata  <= regs[rd_idx];
                rvalid <= 1'b1;
            end else if (rvalid && s_axi.S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RDATA   = rdata;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign s_axi.S_AXI_RVALID  = rvalid;

    assign reg0_ctrl      = regs[0];
    assign reg1_phase_inc = regs[1];
    assign reg2_amplitude = regs[2];
    assign reg3_offset    = regs[3];

    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_sinewave_gen_axil_slave.sv
// Directed bench for the sinewave generator AXI4-Lite register file.
// Drives the bus through the interface and checks registers/handshakes.
module tb_sinewave_gen_axil_slave;
    logic clk;
    logic rst_n;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r3;
    logic upd;
    logic [1:0] upd_idx;
    int n_total;
    int n_bad;
    logic [1:0] upd_q [$];

    sinewave_gen_axil_slave_if vif ();

    sinewave_gen_axil_slave dut (
        .ACLK           (clk),
        .ARESETN        (rst_n),
        .s_axi          (vif.slave),
        .reg0_ctrl      (r0),
        .reg1_phase_inc (r1),
        .reg2_amplitude (r2),
        .reg3_offset    (r3),
        .cfg_update     (upd),
        .cfg_update_idx (upd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd) upd_q.push_back(upd_idx);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic hs_write(input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic aw_go;
        logic w_go;
        vif.S_AXI_AWADDR  = a;
        vif.S_AXI_WDATA   = d;
        vif.S_AXI_WSTRB   = s;
        vif.S_AXI_AWVALID = 1'b1;
        vif.S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!vif.S_AXI_AWVALID && !vif.S_AXI_WVALID) break;
            @(negedge clk);
            aw_go = vif.S_AXI_AWVALID && vif.S_AXI_AWREADY;
            w_go  = vif.S_AXI_WVALID && vif.S_AXI_WREADY;
            @(posedge clk);
            #1;
            if (aw_go) vif.S_AXI_AWVALID = 1'b0;
            if (w_go) vif.S_AXI_WVALID = 1'b0;
        end
        chk("wr_hs_timeout",
            {31'b0, vif.S_AXI_AWVALID | vif.S_AXI_WVALID}, 32'd0);
        vif.S_AXI_AWVALID = 1'b0;
        vif.S_AXI_WVALID  = 1'b0;
    endtask

    task automatic wait_b();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (vif.S_AXI_BVALID) begin
                got = 1'b1;
                chk("bresp", {30'b0, vif.S_AXI_BRESP}, 32'd0);
            end
        end
        chk("b_timeout", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        logic go;
        logic got;
        go  = 1'b0;
        got = 1'b0;
        d   = '0;
        vif.S_AXI_ARADDR  = a;
        vif.S_AXI_ARVALID = 1'b1;
        vif.S_AXI_RREADY  = 1'b0;
        for (int i = 0; i < 100 && !go; i++) begin
            @(negedge clk);
            go = vif.S_AXI_ARREADY;
            @(posedge clk);
            #1;
        end
        vif.S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (vif.S_AXI_RVALID) begin
                got = 1'b1;
                d = vif.S_AXI_RDATA;
                chk("rresp", {30'b0, vif.S_AXI_RRESP}, 32'd0);
            end
        end
        chk("r_timeout", {31'b0, got}, 32'd1);
        vif.S_AXI_RREADY = 1'b1;
        @(posedge clk);
        #1;
        vif.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp_v [4];
        n_total = 0;
        n_bad   = 0;
        rst_n = 1'b0;
        vif.S_AXI_AWADDR  = '0;
        vif.S_AXI_AWPROT  = '0;
        vif.S_AXI_AWVALID = 1'b0;
        vif.S_AXI_WDATA   = '0;
        vif.S_AXI_WSTRB   = '0;
        vif.S_AXI_WVALID  = 1'b0;
        vif.S_AXI_BREADY  = 1'b1;
        vif.S_AXI_ARADDR  = '0;
        vif.S_AXI_ARPROT  = '0;
        vif.S_AXI_ARVALID = 1'b0;
        vif.S_AXI_RREADY  = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_awready", {31'b0, vif.S_AXI_AWREADY}, 0);
        chk("rst_wready", {31'b0, vif.S_AXI_WREADY}, 0);
        chk("rst_arready", {31'b0, vif.S_AXI_ARREADY}, 0);
        chk("rst_bvalid", {31'b0, vif.S_AXI_BVALID}, 0);
        chk("rst_rvalid", {31'b0, vif.S_AXI_RVALID}, 0);
        chk("rst_rdata", vif.S_AXI_RDATA, 0);
        chk("rst_upd", {31'b0, upd}, 0);
        chk("rst_r0", r0, 0);
        chk("rst_r3", r3, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // four writes + readback
        upd_q.delete();
        for (int i = 0; i < 4; i++) begin
            hs_write(4'(i * 4), 32'(i + 1), 4'hF);
            wait_b();
        end
        for (int i = 0; i < 4; i++) begin
            rd(4'(i * 4), d);
            chk("rb4", d, 32'(i + 1));
        end
        chk("upd_cnt4", upd_q.size(), 4);
        for (int i = 0; i < 4 && i < upd_q.size(); i++) begin
            chk("upd_idx", {30'b0, upd_q[i]}, 32'(i));
        end

        // W three cycles ahead of AW
        upd_q.delete();
        vif.S_AXI_WDATA  = 32'hDEADBEEF;
        vif.S_AXI_WSTRB  = 4'hF;
        vif.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        chk("wfirst_wready", {31'b0, vif.S_AXI_WREADY}, 1);
        @(posedge clk);
        #1 vif.S_AXI_WVALID = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("wheld_wready", {31'b0, vif.S_AXI_WREADY}, 0);
            chk("wheld_bvalid", {31'b0, vif.S_AXI_BVALID}, 0);
        end
        vif.S_AXI_AWADDR  = 4'h4;
        vif.S_AXI_AWVALID = 1'b1;
        #1 chk("wfirst_awready", {31'b0, vif.S_AXI_AWREADY}, 1);
        @(posedge clk);
        #1 vif.S_AXI_AWVALID = 1'b0;
        @(negedge clk);
        chk("wfirst_bvalid", {31'b0, vif.S_AXI_BVALID}, 1);
        @(posedge clk);
        #1 chk("wfirst_r1", r1, 32'hDEADBEEF);
        chk("wfirst_upd_cnt", upd_q.size(), 1);
        if (upd_q.size() > 0)
            chk("wfirst_upd_idx", {30'b0, upd_q[0]}, 1);

        // byte strobes, including an all-zero strobe
        hs_write(4'h8, 32'hFFFFFFFF, 4'hF);
        wait_b();
        hs_write(4'h8, 32'h12345678, 4'b0101);
        wait_b();
        chk("strb_r2", r2, 32'hFF34FF78);
        upd_q.delete();
        hs_write(4'h8, 32'h0, 4'h0);
        wait_b();
        chk("strb0_r2", r2, 32'hFF34FF78);
        chk("strb0_upd", upd_q.size(), 1);

        // B backpressure
        vif.S_AXI_BREADY = 1'b0;
        hs_write(4'hC, 32'h11, 4'hF);
        repeat (10) begin
            @(negedge clk);
            chk("bp_bvalid", {31'b0, vif.S_AXI_BVALID}, 1);
            chk("bp_awready", {31'b0, vif.S_AXI_AWREADY}, 0);
            chk("bp_wready", {31'b0, vif.S_AXI_WREADY}, 0);
        end
        chk("bp_r3", r3, 32'h11);
        vif.S_AXI_AWADDR  = 4'hC;
        vif.S_AXI_WDATA   = 32'h22;
        vif.S_AXI_WSTRB   = 4'hF;
        vif.S_AXI_AWVALID = 1'b1;
        vif.S_AXI_WVALID  = 1'b1;
        vif.S_AXI_BREADY  = 1'b1;
        #1 chk("bp_rel_awready", {31'b0, vif.S_AXI_AWREADY}, 0);
        @(negedge clk);
        chk("bp_rel_bvalid", {31'b0, vif.S_AXI_BVALID}, 0);
        chk("bp_rel_awready2", {31'b0, vif.S_AXI_AWREADY}, 1);
        @(posedge clk);
        #1;
        vif.S_AXI_AWVALID = 1'b0;
        vif.S_AXI_WVALID  = 1'b0;
        @(negedge clk);
        chk("bp_b2", {31'b0, vif.S_AXI_BVALID}, 1);
        @(posedge clk);
        #1 chk("bp_r3b", r3, 32'h22);

        // same-edge write and read of reg0
        hs_write(4'h0, 32'h55, 4'hF);
        wait_b();
        vif.S_AXI_AWADDR  = 4'h0;
        vif.S_AXI_WDATA   = 32'hAA;
        vif.S_AXI_WSTRB   = 4'hF;
        vif.S_AXI_ARADDR  = 4'h0;
        vif.S_AXI_AWVALID = 1'b1;
        vif.S_AXI_WVALID  = 1'b1;
        vif.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        chk("sim_rdy", {29'b0, vif.S_AXI_AWREADY,
            vif.S_AXI_WREADY, vif.S_AXI_ARREADY}, 32'd7);
        @(posedge clk);
        #1;
        vif.S_AXI_AWVALID = 1'b0;
        vif.S_AXI_WVALID  = 1'b0;
        vif.S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        chk("sim_rvalid", {31'b0, vif.S_AXI_RVALID}, 1);
        chk("sim_old", vif.S_AXI_RDATA, 32'h55);
        chk("sim_bvalid", {31'b0, vif.S_AXI_BVALID}, 1);
        vif.S_AXI_RREADY = 1'b1;
        @(posedge clk);
        #1 vif.S_AXI_RREADY = 1'b0;
        rd(4'h0, d);
        chk("sim_new", d, 32'hAA);

        // unaligned addresses map to the containing word
        exp_v[0] = 32'hAA;
        exp_v[1] = 32'hDEADBEEF;
        exp_v[2] = 32'hFF34FF78;
        exp_v[3] = 32'h22;
        rd(4'h6, d);
        chk("unal_6", d, exp_v[1]);
        rd(4'hB, d);
        chk("unal_b", d, exp_v[2]);
        rd(4'hF, d);
        chk("unal_f", d, exp_v[3]);

        // R stall then async reset mid-stall
        vif.S_AXI_ARADDR  = 4'h8;
        vif.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        chk("stall_arready", {31'b0, vif.S_AXI_ARREADY}, 1);
        @(posedge clk);
        #1 vif.S_AXI_ARVALID = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_rvalid", {31'b0, vif.S_AXI_RVALID}, 1);
            chk("stall_rdata", vif.S_AXI_RDATA, exp_v[2]);
            chk("stall_arready0", {31'b0, vif.S_AXI_ARREADY}, 0);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rvalid", {31'b0, vif.S_AXI_RVALID}, 0);
        chk("arst_rdata", vif.S_AXI_RDATA, 0);
        chk("arst_regs", r0 | r1 | r2 | r3, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(4'h4, d);
        chk("post_rst_r1", d, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
